timer_display: RTL and testbench

TIMER_DISPLAY -- requirements
Module: timer_display

---
 rtl/timer_display.sv | 176 +++++++++++++++++
 tb/tb_timer_display.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/timer_display.sv
// Binary-to-BCD (double-dabble) converter feeding a scanned 8-digit, 7-segment display.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits 1..4.
module timer_display #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        t_valid,
  input  logic [15:0] t_out,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        busy
);

  localparam int unsigned BIN_W     = 16;
  localparam int unsigned BCD_W     = 20;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned REF_W     = 16;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned LAST_STEP = 15;

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  state_t             r_state, w_state_nxt;
  logic [BIN_W-1:0]   r_bin, w_bin_nxt;
  logic [BCD_W-1:0]   r_bcd, w_bcd_nxt, w_adj;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_pend, w_pend_nxt;
  logic [BIN_W-1:0]   r_pend_val, w_pend_val_nxt;
  logic [BCD_W-1:0]   r_disp, w_disp_nxt;
  logic               w_busy_nxt;
  logic [REF_W-1:0]   r_refresh, w_refresh_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [4:0]         w_lz_show;
  logic [3:0]         w_nib;
  logic               w_show;
  logic [7:0]         w_an_nxt;
  logic [6:0]         w_seg_nxt;

  function automatic logic [6:0] seg_pat(input logic [3:0] d);
    case (d)
      4'd0:    seg_pat = 7'b1000000;
      4'd1:    seg_pat = 7'b1111001;
      4'd2:    seg_pat = 7'b0100100;
      4'd3:    seg_pat = 7'b0110000;
      4'd4:    seg_pat = 7'b0011001;
      4'd5:    seg_pat = 7'b0010010;
      4'd6:    seg_pat = 7'b0000010;
      4'd7:    seg_pat = 7'b1111000;
      4'd8:    seg_pat = 7'b0000000;
      4'd9:    seg_pat = 7'b0010000;
      default: seg_pat = 7'h7F;
    endcase
  endfunction

  // add-3 correction of every BCD nibble ahead of the shift
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 5; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_bin_nxt      = r_bin;
    w_bcd_nxt      = r_bcd;
    w_cnt_nxt      = r_cnt;
    w_pend_nxt     = r_pend;
    w_pend_val_nxt = r_pend_val;
    w_disp_nxt     = r_disp;
    w_busy_nxt     = busy;
    case (r_state)
      IDLE: begin
        if (t_valid || r_pend) begin
          w_bin_nxt   = t_valid ? t_out : r_pend_val;
          w_bcd_nxt   = '0;
          w_cnt_nxt   = '0;
          w_pend_nxt  = 1'b0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = CONV;
        end
      end
      CONV: begin
        w_bcd_nxt = BCD_W'({w_adj, r_bin[BIN_W-1]});
        w_bin_nxt = {r_bin[BIN_W-2:0], 1'b0};
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(LAST_STEP)) w_state_nxt = LOAD;
      end
      LOAD: begin
        w_disp_nxt  = r_bcd;
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    // a value arriving mid-conversion waits; newest wins
    if (t_valid && (r_state != IDLE)) begin
      w_pend_nxt     = 1'b1;
      w_pend_val_nxt = t_out;
    end
  end

  always_comb begin
    w_refresh_nxt = r_refresh + REF_W'(1);
    w_idx_nxt     = r_idx;
    if (r_refresh == REF_W'(REFRESH_DIV - 1)) begin
      w_refresh_nxt = '0;
      w_idx_nxt     = r_idx + IDX_W'(1);
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  assign w_lz_show = {|w_disp_nxt[19:16], |w_disp_nxt[19:12], |w_disp_nxt[19:8],
                      |w_disp_nxt[19:4], 1'b1};
`else
  assign w_lz_show = 5'h1F;
`endif

  // scan outputs follow the next-cycle index and display so they update with busy
  always_comb begin
    w_nib     = 4'd0;
    w_show    = 1'b0;
    w_an_nxt  = 8'hFF;
    w_seg_nxt = 7'h7F;
    case (w_idx_nxt)
      3'd0: begin w_nib = w_disp_nxt[3:0];   w_show = w_lz_show[0]; end
      3'd1: begin w_nib = w_disp_nxt[7:4];   w_show = w_lz_show[1]; end
      3'd2: begin w_nib = w_disp_nxt[11:8];  w_show = w_lz_show[2]; end
      3'd3: begin w_nib = w_disp_nxt[15:12]; w_show = w_lz_show[3]; end
      3'd4: begin w_nib = w_disp_nxt[19:16]; w_show = w_lz_show[4]; end
      default: ;
    endcase
    if (w_show) begin
      w_an_nxt  = ~(8'b1 << w_idx_nxt);
      w_seg_nxt = seg_pat(w_nib);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_pend     <= 1'b0;
      r_pend_val <= '0;
      r_disp     <= '0;
      r_refresh  <= '0;
      r_idx      <= '0;
      busy       <= 1'b0;
      an         <= 8'hFE;
      seg        <= 7'b1000000;
      dp         <= 1'b1;
    end else begin
      r_bin      <= w_bin_nxt;
      r_bcd      <= w_bcd_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pend     <= w_pend_nxt;
      r_pend_val <= w_pend_val_nxt;
      r_disp     <= w_disp_nxt;
      r_refresh  <= w_refresh_nxt;
      r_idx      <= w_idx_nxt;
      busy       <= w_busy_nxt;
      an         <= w_an_nxt;
      seg        <= w_seg_nxt;
      dp         <= 1'b1;
    end
  end

endmodule

// File: tb/tb_timer_display.sv
// Scoreboard bench for timer_display: a value-level model predicts which values get shown and when.
module tb_timer_display;
  localparam int unsigned DIV = 3;
  localparam int CONV_EDGES = 17;

  logic        clk = 1'b0;
  logic        rst, t_valid;
  logic [15:0] t_out;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp, busy;

  timer_display #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .t_valid(t_valid), .t_out(t_out),
    .an(an), .seg(seg), .dp(dp), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // model state
  int rem = 0, n = 0, cur = 0, pend_val = 0;
  bit pend = 1'b0;
  int q[$];
  int hist[$];
  int shown = 0;
  bit prev_busy = 1'b0;

  logic [6:0] pat_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int pow10(input int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  function automatic bit digit_lit(input int v, input int k);
`ifdef LEADING_ZERO_BLANK_EN
    return (k == 0) || (v >= pow10(k));
`else
    return 1'b1;
`endif
  endfunction

  // reference: which value finishes conversion on which edge
  always @(posedge clk) begin
    if (rst) begin
      rem = 0; pend = 1'b0; n = 0; q.delete();
    end else begin
      n++;
      if (rem == 0) begin
        if (t_valid) begin
          cur = int'(t_out); pend = 1'b0; rem = CONV_EDGES;
        end else if (pend) begin
          cur = pend_val; pend = 1'b0; rem = CONV_EDGES;
        end
      end else begin
        if (t_valid) begin pend = 1'b1; pend_val = int'(t_out); end
        rem--;
        if (rem == 0) q.push_back(cur);
      end
    end
  end

  // monitor: adopt a new display value when busy drops, then check the scan
  always @(negedge clk) begin
    int slot;
    int exp_an, exp_seg;
    if (rst) begin
      shown = 0;
    end else if (prev_busy && !busy) begin
      if (q.size() == 0) check("unexpected_update", 1, 0);
      else begin
        shown = q.pop_front();
        hist.push_back(shown);
      end
    end
    prev_busy = busy;
    slot = (n / DIV) % 8;
    exp_an = 8'hFF;
    exp_seg = 7'h7F;
    if (slot < 5 && digit_lit(shown, slot)) begin
      exp_an  = (~(1 << slot)) & 8'hFF;
      exp_seg = int'(pat_tab[(shown / pow10(slot)) % 10]);
    end
    check("busy", int'(busy), (rem > 0) ? 1 : 0);
    check("an", int'(an), exp_an);
    check("seg", int'(seg), exp_seg);
    check("dp", int'(dp), 1);
  end

  task automatic idle(input int nc);
    repeat (nc) @(negedge clk);
    #1;
  endtask

  task automatic pulse(input int val);
    t_valid = 1'b1;
    t_out = 16'(val);
    idle(1);
    t_valid = 1'b0;
  endtask

  initial begin
    int v;
    rst = 1'b1; t_valid = 1'b0; t_out = '0;
    idle(2);
    rst = 1'b0;
    idle(5);

    pulse(12345); idle(50);
    pulse(65535); idle(50);

    pulse(7); idle(3); pulse(100); idle(3); pulse(200); idle(70);
    check("bp_first", hist[hist.size()-2], 7);
    check("bp_second", hist[hist.size()-1], 200);

    pulse(42); idle(50);
    pulse(0);  idle(50);

    pulse(999); idle(8);
    rst = 1'b1; idle(1); rst = 1'b0;
    idle(60);
    check("no_update_after_rst", shown, 0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(5) == 0) begin
        case ($urandom_range(3))
          0: v = 65535;
          1: v = 0;
          default: v = int'($urandom_range(65535));
        endcase
        pulse(v);
      end else idle(1);
    end
    idle(80);
    check("queue_empty", q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
